// File: rtl/fx3_cmd_router_mc.sv
// fx3_cmd_router_mc: decodes the FX3 UART byte stream ({cmd[7:5],payload[4:0]} headers
// plus data bytes), drives GPIO, routes SPI write/read transfers to one of NUM_SPI
// channels and queues response bytes toward the UART TX through a small FWFT FIFO.
// Build macro FX3_ROUTER_DEBUG_EN: when defined, DEBUG payload bytes are forwarded on
// dbg_data/dbg_valid; otherwise they are swallowed to keep the stream framed.
//
// state  | meaning
// S_IDLE | waiting for a command header
// S_WR   | forwarding SPI_WRITE payload bytes to the selected channel
// S_RD   | moving SPI read bytes from the selected channel into the response FIFO
// S_DBG  | consuming DEBUG payload bytes
module fx3_cmd_router_mc #(
    parameter int GPIO_W      = 32,
    parameter int NUM_SPI     = 2,
    parameter int RSP_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 uart_sample_clock,
    input  logic                 reset_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [GPIO_W-1:0]    gpio_in,
    output logic [GPIO_W-1:0]    gpio_oe,
    output logic [GPIO_W-1:0]    gpio_out,
    output logic [7:0]           spi_wr_data,
    output logic [NUM_SPI-1:0]   spi_wr_en,
    output logic [NUM_SPI-1:0]   spi_wr_commit,
    input  logic [NUM_SPI-1:0]   spi_wr_full,
    output logic [NUM_SPI-1:0]   spi_rd_start,
    output logic [4:0]           spi_rd_count,
    input  logic [8*NUM_SPI-1:0] spi_rd_data,
    input  logic [NUM_SPI-1:0]   spi_rd_valid,
    output logic [NUM_SPI-1:0]   spi_rd_en,
    output logic [7:0]           dbg_data,
    output logic                 dbg_valid,
    output logic                 err_timeout,
    output logic                 busy
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DBG} state_t;

    state_t              state_q, state_d;
    logic [4:0]          rem_q, rem_d;
    logic [1:0]          ch_q, ch_d;
    logic [GPIO_W-1:0]   oe_q, oe_d, out_q, out_d;
    logic                bad_ch_q, bad_ch_d, to_q, to_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                push_q, push_d;
    logic [7:0]          push_data_q, push_data_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]          mem_q [RSP_DEPTH];
    logic [7:0]          wr_data_q, wr_data_d;
    logic [NUM_SPI-1:0]  wr_en_q, wr_en_d, commit_pend_q, commit_pend_d, commit_q, commit_d;
    logic [NUM_SPI-1:0]  rd_start_q, rd_start_d;
    logic [4:0]          rd_count_q, rd_count_d;
    logic                err_q, err_d;
`ifdef FX3_ROUTER_DEBUG_EN
    logic [7:0]          dbg_data_q, dbg_data_d;
    logic                dbg_valid_q, dbg_valid_d;
`endif

    logic [2:0]          hdr_cmd;
    logic [4:0]          hdr_p;
    logic [GPIO_W-1:0]   gpio_mask;
    logic [NUM_SPI-1:0]  ch_oh;
    logic [7:0]          rd_byte;
    logic                wr_full_sel, rd_valid_sel;
    logic [AW+1:0]       rsp_occ;
    logic                rsp_full, rx_fire, tx_fire, progress, rx_ready_raw;

    assign hdr_cmd     = rx_data[7:5];
    assign hdr_p       = rx_data[4:0];
    // shifting past GPIO_W yields an empty mask, which is exactly the out-of-range behaviour
    assign gpio_mask   = GPIO_W'(1) << hdr_p;
    assign ch_oh       = NUM_SPI'(1) << ch_q;
    assign wr_full_sel = |(spi_wr_full & ch_oh);
    assign rd_valid_sel = |(spi_rd_valid & ch_oh);
    // a push waiting in the staging register already owns a FIFO slot
    assign rsp_occ     = {1'b0, wr_ptr_q - rd_ptr_q} + {{(AW+1){1'b0}}, push_q};
    assign rsp_full    = (rsp_occ == (AW+2)'(RSP_DEPTH));
    assign tx_valid    = (wr_ptr_q != rd_ptr_q);
    assign tx_data     = tx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign tx_fire     = tx_valid && tx_ready;
    assign rx_fire     = rx_valid && rx_ready;

    // read byte of the selected channel
    always_comb begin
        rd_byte = 8'h00;
        for (int c = 0; c < NUM_SPI; c++) begin
            if (ch_q == 2'(c)) rd_byte = spi_rd_data[8*c +: 8];
        end
    end

    // per-state input readiness, held low while in reset
    always_comb begin
        rx_ready_raw = 1'b0;
        unique case (state_q)
            S_IDLE:  rx_ready_raw = !rsp_full;
            S_WR:    rx_ready_raw = !wr_full_sel;
            S_DBG:   rx_ready_raw = 1'b1;
            default: rx_ready_raw = 1'b0;
        endcase
        rx_ready = rx_ready_raw && reset_n;
    end

    // command decode, payload handling, timeout and FIFO pointer next-state
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        ch_d          = ch_q;
        oe_d          = oe_q;
        out_d         = out_q;
        bad_ch_d      = bad_ch_q;
        to_d          = to_q;
        tmo_d         = tmo_q;
        push_d        = 1'b0;
        push_data_d   = 8'h00;
        wr_data_d     = wr_data_q;
        wr_en_d       = '0;
        commit_pend_d = '0;
        commit_d      = commit_pend_q;
        rd_start_d    = '0;
        rd_count_d    = rd_count_q;
        err_d         = 1'b0;
        spi_rd_en     = '0;
        progress      = 1'b0;
        wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push_q};
        rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, tx_fire};
`ifdef FX3_ROUTER_DEBUG_EN
        dbg_data_d    = dbg_data_q;
        dbg_valid_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    tmo_d = '0;
                    unique case (hdr_cmd)
                        3'd0: begin
                            oe_d        = oe_q & ~gpio_mask;
                            push_d      = 1'b1;
                            push_data_d = {7'b0, |(gpio_in & gpio_mask)};
                        end
                        3'd1: begin
                            oe_d  = oe_q | gpio_mask;
                            out_d = out_q | gpio_mask;
                        end
                        3'd2: begin
                            oe_d  = oe_q | gpio_mask;
                            out_d = out_q & ~gpio_mask;
                        end
                        3'd3: if (hdr_p != 5'd0) begin
                            rd_start_d = ch_oh;
                            rd_count_d = hdr_p;
                            rem_d      = hdr_p;
                            state_d    = S_RD;
                        end
                        3'd4: if (hdr_p != 5'd0) begin
                            rem_d   = hdr_p;
                            state_d = S_WR;
                        end
                        3'd5: if (hdr_p != 5'd0) begin
                            rem_d   = hdr_p;
                            state_d = S_DBG;
                        end
                        3'd6: begin
                            if (32'(hdr_p[1:0]) < NUM_SPI) ch_d = hdr_p[1:0];
                            else bad_ch_d = 1'b1;
                        end
                        default: begin
                            push_d      = 1'b1;
                            push_data_d = {to_q, bad_ch_q, 4'b0, ch_q};
                            to_d        = 1'b0;
                            bad_ch_d    = 1'b0;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (rx_fire) begin
                    progress  = 1'b1;
                    wr_data_d = rx_data;
                    wr_en_d   = ch_oh;
                    rem_d     = rem_q - 5'd1;
                    if (rem_q == 5'd1) begin
                        commit_pend_d = ch_oh;
                        state_d       = S_IDLE;
                    end
                end
            end
            S_RD: begin
                if (rd_valid_sel && !rsp_full) begin
                    progress    = 1'b1;
                    spi_rd_en   = ch_oh;
                    push_d      = 1'b1;
                    push_data_d = rd_byte;
                    rem_d       = rem_q - 5'd1;
                    if (rem_q == 5'd1) state_d = S_IDLE;
                end
            end
            default: begin
                if (rx_fire) begin
                    progress = 1'b1;
`ifdef FX3_ROUTER_DEBUG_EN
                    dbg_data_d  = rx_data;
                    dbg_valid_d = 1'b1;
`endif
                    rem_d = rem_q - 5'd1;
                    if (rem_q == 5'd1) state_d = S_IDLE;
                end
            end
        endcase
        if (state_q != S_IDLE) begin
            if (progress) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                tmo_d   = '0;
                state_d = S_IDLE;
                err_d   = 1'b1;
                to_d    = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge uart_sample_clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            ch_q          <= '0;
            oe_q          <= '0;
            out_q         <= '0;
            bad_ch_q      <= 1'b0;
            to_q          <= 1'b0;
            tmo_q         <= '0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= '0;
            commit_pend_q <= '0;
            commit_q      <= '0;
            rd_start_q    <= '0;
            rd_count_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            ch_q          <= ch_d;
            oe_q          <= oe_d;
            out_q         <= out_d;
            bad_ch_q      <= bad_ch_d;
            to_q          <= to_d;
            tmo_q         <= tmo_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            commit_pend_q <= commit_pend_d;
            commit_q      <= commit_d;
            rd_start_q    <= rd_start_d;
            rd_count_q    <= rd_count_d;
            err_q         <= err_d;
        end
    end

    // FIFO storage; contents need no reset because tx_data is masked while empty
    always_ff @(posedge uart_sample_clock) begin
        if (push_q) mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
    end

`ifdef FX3_ROUTER_DEBUG_EN
    // debug byte forwarding register
    always_ff @(posedge uart_sample_clock) begin
        if (!reset_n) begin
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            dbg_data_q  <= dbg_data_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end
    assign dbg_data  = dbg_data_q;
    assign dbg_valid = dbg_valid_q;
`else
    assign dbg_data  = 8'h00;
    assign dbg_valid = 1'b0;
`endif

    assign gpio_oe       = oe_q;
    assign gpio_out      = out_q;
    assign spi_wr_data   = wr_data_q;
    assign spi_wr_en     = wr_en_q;
    assign spi_wr_commit = commit_q;
    assign spi_rd_start  = rd_start_q;
    assign spi_rd_count  = rd_count_q;
    assign err_timeout   = err_q;
    assign busy          = (state_q != S_IDLE);
endmodule
